dig_count_down: RTL and testbench
=================================

Name: dig_count_down

Overview:
- Countdown timer core for the typing game; counts a preset time down to zero in 0.01 s units.
- Drives an 8-digit multiplexed 7-segment display with the remaining time.
- The game controller loads the preset while idle, starts and pauses counting through clock_go, and detects timeout by watching last_time reach 0.

Parameters:
- TICK_DIV, 1_000_000: clk cycles per count unit; 0.01 s at 100 MHz.
- SCAN_DIV, 100_000: clk cycles each digit stays enabled during display scan.
- MAX_TIME, 99_999_999: largest representable value; 8 decimal digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- setting_change  in  1  1 = load mode: last_time tracks start_time.
- start_time  in  27  preset time, binary, units of 0.01 s.
- clock_go  in  1  1 = count down; 0 = hold (paused or stopped).
- last_time  out  27  remaining time, binary, units of 0.01 s.
- DIG  out  8  digit enables, active-low one-hot; DIG[0] = least-significant digit.
- SEG  out  8  segments, active-low: SEG[7]=dp, SEG[6:0]=g,f,e,d,c,b,a.

Behaviour:
- Reset (rst=0, asynchronous):
  - last_time=0, tick prescaler=0, scan prescaler=0, scan index=0.
  - DIG=8'hFF, SEG=8'hFF (all dark).
  - On release, scanning begins at digit 0 after the first SCAN_DIV period.
- Load:
  - Each clk with setting_change=1: last_time <= min(start_time, MAX_TIME); tick prescaler cleared.
  - setting_change has priority over clock_go.
- Count:
  - Applies when setting_change=0 and clock_go=1.
  - Tick prescaler counts 0..TICK_DIV-1.
  - On the cycle it wraps, if last_time != 0 then last_time decrements by 1.
  - First decrement occurs exactly TICK_DIV cycles after clock_go rises, provided the prescaler was cleared by load.
- Hold:
  - Applies when setting_change=0 and clock_go=0.
  - last_time and tick prescaler both frozen; resuming continues the partial tick.
- Zero: last_time saturates at 0 and never wraps; prescaler may keep running.
- BCD:
  - last_time is converted to 8 BCD digits d7..d0, d0 = hundredths.
  - Either combinational, or sequential double-dabble of ≤32 cycles restarted whenever last_time changes.
  - Displayed digits lag last_time by at most 32 cycles.
- Scan:
  - Scan prescaler wraps every SCAN_DIV cycles and then advances the index 0→1→…→7→0.
  - DIG = ~(1<<index); SEG = pattern of d[index].
  - All 8 digits are always shown, leading zeros included.
- Segment patterns (SEG[6:0]): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- SEG[7]=1 (dp off) unless the optional feature is enabled.
- Simultaneous events: load beats count. A decrement and a new start_time in the same cycle with setting_change=1 → the load wins.
- Reset mid-count: immediate clear as above; no residual tick.

Optional Feature:
- Macro COUNTDOWN_DP_EN.
- When defined: SEG[7]=0 (dp lit) whenever index==2, marking seconds.hundredths, e.g. "000012.00".
- When undefined: SEG[7] is constantly 1.

Test Plan:
- Use TICK_DIV=4, SCAN_DIV=2 for simulation.
- Reset: rst=0 mid-operation → last_time=0, DIG=FF, SEG=FF immediately, without waiting for a clk edge.
- Load 1200: setting_change=1, start_time=1200 → last_time=1200 next clk. Scan shows d0=0, d1=0, d2=2, d3=1, d4..d7=0; digit 3 enabled → DIG=F7, SEG=F9 (dp off).
- Count/pause:
  - setting_change=0, clock_go=1 for 12 cycles → last_time=1197.
  - clock_go=0 for 50 cycles → last_time stays 1197.
  - clock_go=1 for 4 more cycles → 1196.
- Saturation: load 2, then count 40 cycles → last_time=0 and remains 0; display all zeros (SEG=C0 each digit).
- Clamp/priority: start_time=120_000_000 with setting_change=1 and clock_go=1 → last_time=99_999_999, no decrement while setting_change=1; all digits show 9 (SEG=90).
- COUNTDOWN_DP_EN defined: at index 2, SEG[7]=0; at all other indices, SEG[7]=1.

Source files
------------

// File: rtl/dig_count_down.sv
// Countdown timer core with an 8-digit multiplexed 7-segment display of the remaining time.
// Define COUNTDOWN_DP_EN to light the decimal point on digit 2 (seconds.hundredths).
module dig_count_down #(
  parameter int TICK_DIV = 1_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter int MAX_TIME = 99_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        setting_change,
  input  logic [26:0] start_time,
  input  logic        clock_go,
  output logic [26:0] last_time,
  output logic [7:0]  DIG,
  output logic [7:0]  SEG
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [26:0]   MAX_T     = 27'(MAX_TIME);

  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    scan_idx;
  logic          scan_on;
  logic [31:0]   bcd;
  logic [3:0]    digit;
  logic [6:0]    seg7;
  logic          dp;

  // Load has priority over counting; hold freezes both time and prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_time <= '0;
      tick_cnt  <= '0;
    end else if (setting_change) begin
      last_time <= (start_time > MAX_T) ? MAX_T : start_time;
      tick_cnt  <= '0;
    end else if (clock_go) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        if (last_time != '0)
          last_time <= last_time - 27'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // The first scan wrap only turns the display on, so digit 0 is shown first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      scan_on  <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_on  <= 1'b1;
      if (scan_on)
        scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Combinational double-dabble; MAX_TIME keeps the result within 8 digits.
  always_comb begin
    bcd = '0;
    for (int i = 26; i >= 0; i--) begin
      for (int d = 0; d < 8; d++) begin
        if (bcd[d*4 +: 4] > 4'd4)
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[30:0], last_time[i]};
    end
  end

  assign digit = bcd[{scan_idx, 2'b00} +: 4];

  always_comb begin
    seg7 = 7'h7F;
    case (digit)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  end

`ifdef COUNTDOWN_DP_EN
  assign dp = (scan_idx != 3'd2);
`else
  assign dp = 1'b1;
`endif

  assign DIG = scan_on ? ~(8'd1 << scan_idx) : 8'hFF;
  assign SEG = scan_on ? {dp, seg7} : 8'hFF;

endmodule

// File: tb/tb_dig_count_down.sv
// Self-checking bench for dig_count_down with short prescalers (TICK_DIV=4, SCAN_DIV=2).
// Expected times are queued when stimulus is applied and popped when the result is sampled.
module tb_dig_count_down;

  logic        clk = 1'b0;
  logic        rst;
  logic        setting_change;
  logic [26:0] start_time;
  logic        clock_go;
  logic [26:0] last_time;
  logic [7:0]  DIG;
  logic [7:0]  SEG;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [26:0] val;
  } exp_t;
  exp_t sb_q[$];

  dig_count_down #(.TICK_DIV(4), .SCAN_DIV(2), .MAX_TIME(99_999_999)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .setting_change (setting_change),
    .start_time     (start_time),
    .clock_go       (clock_go),
    .last_time      (last_time),
    .DIG            (DIG),
    .SEG            (SEG)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [26:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, 32'(last_time), 32'(e.val));
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Samples the display for n cycles and checks each shown digit against v.
  task automatic scan_chk(input string tag, input int v, input int n);
    logic [7:0] seen = '0;
    for (int c = 0; c < n; c++) begin
      int idx = -1;
      int zeros = 0;
      logic dp_exp;
      @(posedge clk);
      #1;
      for (int b = 0; b < 8; b++)
        if (!DIG[b]) begin
          zeros++;
          idx = b;
        end
      chk({tag, "_onehot"}, 32'(zeros), 32'd1);
      if (idx >= 0) begin
        int p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
`ifdef COUNTDOWN_DP_EN
        dp_exp = (idx != 2);
`else
        dp_exp = 1'b1;
`endif
        seen[idx] = 1'b1;
        chk({tag, "_seg"}, 32'(SEG), 32'({dp_exp, seg_of((v / p) % 10)}));
      end
    end
    chk({tag, "_cover"}, 32'(seen), 32'hFF);
  endtask

  task automatic load(input logic [26:0] v);
    @(negedge clk);
    setting_change = 1'b1;
    start_time     = v;
  endtask

  initial begin
    rst = 1'b0;
    setting_change = 1'b0;
    start_time = '0;
    clock_go = 1'b0;
    #1;
    chk("rst_time", 32'(last_time), 32'd0);
    chk("rst_dig", 32'(DIG), 32'hFF);
    chk("rst_seg", 32'(SEG), 32'hFF);

    @(negedge clk);
    rst = 1'b1;
    cycles(1);
    chk("scan_wait_dig", 32'(DIG), 32'hFF);
    cycles(1);
    chk("scan_first_dig", 32'(DIG), 32'hFE);
    chk("scan_first_seg", 32'(SEG), 32'hC0);

    load(27'd1200);
    push("load1200", 27'd1200);
    cycles(1);
    pop_chk();
    @(negedge clk);
    setting_change = 1'b0;
    scan_chk("disp1200", 1200, 18);

    load(27'd1200);
    @(negedge clk);
    setting_change = 1'b0;
    clock_go = 1'b1;
    push("cnt3", 27'd1200);
    push("cnt4", 27'd1199);
    push("cnt12", 27'd1197);
    cycles(3);  pop_chk();
    cycles(1);  pop_chk();
    cycles(8);  pop_chk();

    @(negedge clk);
    clock_go = 1'b0;
    push("pause50", 27'd1197);
    cycles(50); pop_chk();

    @(negedge clk);
    clock_go = 1'b1;
    push("resume4", 27'd1196);
    cycles(4);  pop_chk();

    @(negedge clk);
    clock_go = 1'b1;
    push("partial2", 27'd1196);
    cycles(2);  pop_chk();
    @(negedge clk);
    clock_go = 1'b0;
    cycles(10);
    @(negedge clk);
    clock_go = 1'b1;
    push("partial_r1", 27'd1196);
    push("partial_r2", 27'd1195);
    cycles(1);  pop_chk();
    cycles(1);  pop_chk();

    load(27'd2);
    @(negedge clk);
    setting_change = 1'b0;
    clock_go = 1'b1;
    push("sat40", 27'd0);
    push("sat50", 27'd0);
    cycles(40); pop_chk();
    cycles(10); pop_chk();
    scan_chk("disp0", 0, 18);

    load(27'd120_000_000);
    clock_go = 1'b1;
    push("clamp1", 27'd99_999_999);
    push("clamp10", 27'd99_999_999);
    cycles(1);  pop_chk();
    cycles(9);  pop_chk();
    scan_chk("disp9", 99_999_999, 18);

    @(negedge clk);
    setting_change = 1'b0;
    cycles(2);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_time", 32'(last_time), 32'd0);
    chk("midrst_dig", 32'(DIG), 32'hFF);
    chk("midrst_seg", 32'(SEG), 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    cycles(1);
    chk("rescan_wait", 32'(DIG), 32'hFF);
    cycles(1);
    chk("rescan_dig", 32'(DIG), 32'hFE);
    push("post_rst", 27'd0);
    cycles(8);  pop_chk();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
